// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - per-button 2-FF synchronizer, debouncer and press/release pulses
// Optional long-press pulse on o_long when BTN_DEBOUNCE_LONGPRESS_EN is defined (tied low otherwise).

module btn_debounce #(
    parameter int NUM_BTN         = 4,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int LONG_CYCLES     = 100000000,
    parameter int ACTIVE_LOW      = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_BTN-1:0] i_btn,
    output logic [NUM_BTN-1:0] o_level,
    output logic [NUM_BTN-1:0] o_press,
    output logic [NUM_BTN-1:0] o_release,
    output logic [NUM_BTN-1:0] o_long
);

    localparam int            CW       = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [NUM_BTN-1:0] raw;
    logic [NUM_BTN-1:0] sync1;
    logic [NUM_BTN-1:0] sync2;
    logic [NUM_BTN-1:0] accept;

    // Pins are normalised to 1 = pressed before they enter the synchronizer.
    assign raw = (ACTIVE_LOW != 0) ? ~i_btn : i_btn;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
        logic [CW-1:0] cnt;
        logic          level_q;
        logic          press_q;
        logic          rel_q;

        // A change is accepted on the DEBOUNCE_CYCLES-th consecutive disagreeing sample.
        assign accept[i] = (sync2[i] != level_q) && (cnt == CNT_LAST);

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt     <= '0;
                level_q <= 1'b0;
                press_q <= 1'b0;
                rel_q   <= 1'b0;
            end else begin
                press_q <= accept[i] & sync2[i];
                rel_q   <= accept[i] & ~sync2[i];
                if (sync2[i] == level_q) begin
                    cnt <= '0;
                end else if (accept[i]) begin
                    cnt     <= '0;
                    level_q <= sync2[i];
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end

        assign o_level[i]   = level_q;
        assign o_press[i]   = press_q;
        assign o_release[i] = rel_q;

`ifdef BTN_DEBOUNCE_LONGPRESS_EN
        localparam int            HW        = $clog2(LONG_CYCLES);
        localparam logic [HW-1:0] HOLD_FIRE = HW'(LONG_CYCLES - 2);
        localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYCLES - 1);

        logic [HW-1:0] hold;
        logic          long_q;

        // Hold count starts the cycle o_press is high and saturates, so one o_long per press.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                hold   <= '0;
                long_q <= 1'b0;
            end else begin
                long_q <= 1'b0;
                if (!level_q || accept[i]) begin
                    hold <= '0;
                end else if (hold != HOLD_LAST) begin
                    hold   <= hold + 1'b1;
                    long_q <= (hold == HOLD_FIRE);
                end
            end
        end

        assign o_long[i] = long_q;
`else
        // Always 0 (LONG_CYCLES >= 2); the expression keeps LONG_CYCLES referenced in this build.
        assign o_long[i] = (LONG_CYCLES < 1);
`endif
    end

endmodule

// File: tb/tb_btn_debounce.sv
// tb/tb_btn_debounce.sv - directed and randomized bench for btn_debounce (active-high and active-low)
// Long-press expectations follow BTN_DEBOUNCE_LONGPRESS_EN as defined for the build.

module tb_btn_debounce;

    localparam int NB = 4;
    localparam int DC = 8;
    localparam int LC = 32;
`ifdef BTN_DEBOUNCE_LONGPRESS_EN
    localparam bit LONG_EN = 1'b1;
`else
    localparam bit LONG_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic [NB-1:0] btn;
    logic [NB-1:0] btn_pin;
    logic [NB-1:0] lvl_a, prs_a, rel_a, lng_a;
    logic [NB-1:0] lvl_b, prs_b, rel_b, lng_b;
    logic [15:0]   obs_a, obs_b;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always #5 clk = ~clk;

    assign btn_pin = ~btn;
    assign obs_a   = {lvl_a, prs_a, rel_a, lng_a};
    assign obs_b   = {lvl_b, prs_b, rel_b, lng_b};

    btn_debounce #(.NUM_BTN(NB), .DEBOUNCE_CYCLES(DC), .LONG_CYCLES(LC), .ACTIVE_LOW(0)) dut_a (
        .clk(clk), .rst_n(rst_n), .i_btn(btn),
        .o_level(lvl_a), .o_press(prs_a), .o_release(rel_a), .o_long(lng_a)
    );

    btn_debounce #(.NUM_BTN(NB), .DEBOUNCE_CYCLES(DC), .LONG_CYCLES(LC), .ACTIVE_LOW(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .i_btn(btn_pin),
        .o_level(lvl_b), .o_press(prs_b), .o_release(rel_b), .o_long(lng_b)
    );

    // Reference model: a change is accepted when the last DC synchronized samples
    // (input delayed by two edges, zero right after reset) all differ from the level.
    logic [NB-1:0] m_level = '0, m_press = '0, m_rel = '0, m_long = '0;
    logic [NB-1:0] hist[$];
    int            age[NB];
    bit            all_diff;
    bit            smp;
    int            idx;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist.delete();
            m_level = '0; m_press = '0; m_rel = '0; m_long = '0;
            for (int i = 0; i < NB; i++) age[i] = 0;
        end else begin
            cyc++;
            hist.push_back(btn);
            if (hist.size() > DC + 2) void'(hist.pop_front());
            m_press = '0; m_rel = '0; m_long = '0;
            for (int i = 0; i < NB; i++) begin
                all_diff = 1'b1;
                for (int j = 0; j < DC; j++) begin
                    idx = hist.size() - 3 - j;
                    smp = (idx >= 0) ? hist[idx][i] : 1'b0;
                    if (smp == m_level[i]) all_diff = 1'b0;
                end
                if (all_diff) begin
                    m_level[i] = ~m_level[i];
                    m_press[i] = m_level[i];
                    m_rel[i]   = ~m_level[i];
                    age[i]     = 0;
                end else if (m_level[i]) begin
                    age[i]++;
                    if (LONG_EN && age[i] == LC - 1) m_long[i] = 1'b1;
                end
            end
        end
    end

    task automatic test_reset;
        rst_n = 1'b0;
        btn   = '0;
        repeat (3) @(negedge clk);
        total++;
        if (obs_a !== 16'h0) begin bad++; $display("FAIL reset_a got=%h exp=%h", obs_a, 16'h0); end
        total++;
        if (obs_b !== 16'h0) begin bad++; $display("FAIL reset_b got=%h exp=%h", obs_b, 16'h0); end
        rst_n = 1'b1;
    endtask

    task automatic test_clean_press;
        logic [NB-1:0] el, ep, er;
        for (int p = 0; p < 2; p++) begin
            btn = (p == 0) ? 4'b0001 : 4'b0000;
            for (int n = 0; n < 20; n++) begin
                @(negedge clk);
                el = ((p == 0) == (n >= 9)) ? 4'b0001 : 4'b0000;
                ep = (p == 0 && n == 9) ? 4'b0001 : 4'b0000;
                er = (p == 1 && n == 9) ? 4'b0001 : 4'b0000;
                total++;
                if (obs_a !== {el, ep, er, 4'b0}) begin
                    bad++; $display("FAIL clean_a p=%0d n=%0d got=%h exp=%h", p, n, obs_a, {el, ep, er, 4'b0});
                end
                total++;
                if (obs_b !== {el, ep, er, 4'b0}) begin
                    bad++; $display("FAIL clean_b p=%0d n=%0d got=%h exp=%h", p, n, obs_b, {el, ep, er, 4'b0});
                end
            end
        end
    endtask

    task automatic test_bounce;
        logic [NB-1:0] el, ep, er;
        for (int c = 0; c < 40; c++) begin
            btn = '0;
            btn[1] = ((c / 3) % 2 == 0);
            @(negedge clk);
            total++;
            if (obs_a !== 16'h0) begin bad++; $display("FAIL bounce_a c=%0d got=%h exp=%h", c, obs_a, 16'h0); end
        end
        for (int p = 0; p < 2; p++) begin
            btn = (p == 0) ? 4'b0010 : 4'b0000;
            for (int n = 0; n < 20; n++) begin
                @(negedge clk);
                el = ((p == 0) == (n >= 9)) ? 4'b0010 : 4'b0000;
                ep = (p == 0 && n == 9) ? 4'b0010 : 4'b0000;
                er = (p == 1 && n == 9) ? 4'b0010 : 4'b0000;
                total++;
                if (obs_a !== {el, ep, er, 4'b0}) begin
                    bad++; $display("FAIL settle_a p=%0d n=%0d got=%h exp=%h", p, n, obs_a, {el, ep, er, 4'b0});
                end
            end
        end
    endtask

    task automatic test_glitch;
        for (int n = 0; n < 24; n++) begin
            btn = (n < 7) ? 4'b0100 : 4'b0000;
            @(negedge clk);
            total++;
            if (obs_a !== 16'h0) begin bad++; $display("FAIL glitch_a n=%0d got=%h exp=%h", n, obs_a, 16'h0); end
            total++;
            if (obs_b !== 16'h0) begin bad++; $display("FAIL glitch_b n=%0d got=%h exp=%h", n, obs_b, 16'h0); end
        end
    endtask

    task automatic test_simultaneous;
        logic [NB-1:0] el, ep, er;
        for (int p = 0; p < 2; p++) begin
            btn = (p == 0) ? 4'b1011 : 4'b0000;
            for (int n = 0; n < 20; n++) begin
                @(negedge clk);
                el = ((p == 0) == (n >= 9)) ? 4'b1011 : 4'b0000;
                ep = (p == 0 && n == 9) ? 4'b1011 : 4'b0000;
                er = (p == 1 && n == 9) ? 4'b1011 : 4'b0000;
                total++;
                if (obs_a !== {el, ep, er, 4'b0}) begin
                    bad++; $display("FAIL simul_a p=%0d n=%0d got=%h exp=%h", p, n, obs_a, {el, ep, er, 4'b0});
                end
                total++;
                if (obs_b !== {el, ep, er, 4'b0}) begin
                    bad++; $display("FAIL simul_b p=%0d n=%0d got=%h exp=%h", p, n, obs_b, {el, ep, er, 4'b0});
                end
            end
        end
    endtask

    task automatic test_reset_mid;
        logic [NB-1:0] el, ep, er;
        btn = 4'b0001;
        repeat (20) @(negedge clk);
        total++;
        if (lvl_a !== 4'b0001) begin bad++; $display("FAIL pre_reset_lvl got=%h exp=%h", lvl_a, 4'b0001); end
        btn = 4'b1001;
        repeat (7) @(negedge clk);
        rst_n = 1'b0;
        #1;
        total++;
        if (obs_a !== 16'h0) begin bad++; $display("FAIL async_reset_a got=%h exp=%h", obs_a, 16'h0); end
        total++;
        if (obs_b !== 16'h0) begin bad++; $display("FAIL async_reset_b got=%h exp=%h", obs_b, 16'h0); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int p = 0; p < 2; p++) begin
            btn = (p == 0) ? 4'b1001 : 4'b0000;
            for (int n = 0; n < 20; n++) begin
                @(negedge clk);
                el = ((p == 0) == (n >= 9)) ? 4'b1001 : 4'b0000;
                ep = (p == 0 && n == 9) ? 4'b1001 : 4'b0000;
                er = (p == 1 && n == 9) ? 4'b1001 : 4'b0000;
                total++;
                if (obs_a !== {el, ep, er, 4'b0}) begin
                    bad++; $display("FAIL post_reset_a p=%0d n=%0d got=%h exp=%h", p, n, obs_a, {el, ep, er, 4'b0});
                end
            end
        end
    endtask

    task automatic test_long_press;
        logic [NB-1:0] el, ep, er, elg;
        for (int p = 0; p < 2; p++) begin
            btn = (p == 0) ? 4'b0001 : 4'b0000;
            for (int n = 0; n < ((p == 0) ? 60 : 20); n++) begin
                @(negedge clk);
                el  = ((p == 0) == (n >= 9)) ? 4'b0001 : 4'b0000;
                ep  = (p == 0 && n == 9) ? 4'b0001 : 4'b0000;
                er  = (p == 1 && n == 9) ? 4'b0001 : 4'b0000;
                elg = (LONG_EN && p == 0 && n == 9 + LC - 1) ? 4'b0001 : 4'b0000;
                total++;
                if (obs_a !== {el, ep, er, elg}) begin
                    bad++; $display("FAIL long_a p=%0d n=%0d got=%h exp=%h", p, n, obs_a, {el, ep, er, elg});
                end
                total++;
                if (obs_b !== {el, ep, er, elg}) begin
                    bad++; $display("FAIL long_b p=%0d n=%0d got=%h exp=%h", p, n, obs_b, {el, ep, er, elg});
                end
            end
        end
    endtask

    task automatic test_random;
        int left[NB];
        for (int i = 0; i < NB; i++) left[i] = $urandom_range(1, 12);
        btn = '0;
        for (int c = 0; c < 2500; c++) begin
            for (int i = 0; i < NB; i++) begin
                if (left[i] == 0) begin
                    btn[i]  = ~btn[i];
                    left[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(20, 45) : $urandom_range(1, 12);
                end
                left[i]--;
            end
            if (c == 1200) rst_n = 1'b0;
            if (c == 1202) rst_n = 1'b1;
            @(negedge clk);
            total++;
            if (obs_a !== {m_level, m_press, m_rel, m_long}) begin
                bad++; $display("FAIL random_a c=%0d cyc=%0d got=%h exp=%h", c, cyc, obs_a, {m_level, m_press, m_rel, m_long});
            end
            total++;
            if (obs_b !== {m_level, m_press, m_rel, m_long}) begin
                bad++; $display("FAIL random_b c=%0d cyc=%0d got=%h exp=%h", c, cyc, obs_b, {m_level, m_press, m_rel, m_long});
            end
        end
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_glitch();
        test_simultaneous();
        test_reset_mid();
        test_long_press();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
